// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//
// Instruction-fetch stage plus the IF/ID pipeline register. Takes the
// word-address PC from the PC unit, fetches the word from instruction memory
// over a req/ack handshake and presents it, with its decoded fields, to the
// decode stage. A one-entry skid buffer absorbs a word that arrives while
// decode is stalled. A flush (taken branch/jump) discards everything fetched.
//
// Ports
//   clk         rising-edge clock
//   rstd        synchronous active-low reset
//   pc_in       current PC (word address)
//   pc_hold     1 = PC unit must not advance this cycle
//   imem_req    fetch request (registered)
//   imem_addr   fetch word address (registered, stable while imem_req=1)
//   imem_ack    read data valid, sampled while imem_req=1
//   imem_rdata  instruction word from memory
//   stall_in    decode cannot accept; hold IF/ID contents
//   flush_in    taken branch/jump; discard all fetched instructions
//   id_valid    IF/ID register holds a live instruction
//   id_instr    instruction word in IF/ID
//   id_pc       PC of id_instr
//   id_op       id_instr[31:26]
//   id_rs       id_instr[25:21]
//   id_rt       id_instr[20:16]
//   id_imm_dpl  sign-extended id_instr[15:0]
//   id_addr     id_instr[25:0]
// ---------------------------------------------------------------------------
module if_id_stage #(
    parameter int          ADDR_W = 32,
    parameter logic [31:0] NOP    = 32'h00000000
) (
    input  logic              clk,
    input  logic              rstd,
    input  logic [31:0]       pc_in,
    output logic              pc_hold,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall_in,
    input  logic              flush_in,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [31:0]       id_pc,
    output logic [5:0]        id_op,
    output logic [4:0]        id_rs,
    output logic [4:0]        id_rt,
    output logic [31:0]       id_imm_dpl,
    output logic [25:0]       id_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        issue;
    logic        accept;
    logic        id_busy;
    logic [31:0] req_pc;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;

    // Next-state logic. A new fetch is only issued when the skid is empty,
    // which guarantees a skid drain and a fresh ack never land together.
    // KILL waits out the abandoned request because memory cannot be retracted.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (!flush_in && !skid_valid) begin
                    issue      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    state_next = IDLE;
                    accept     = !flush_in;
                end else if (flush_in) begin
                    state_next = KILL;
                end
            end
            KILL: begin
                if (imem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The PC moves once per accepted word, or to the branch target on a flush;
    // it is frozen throughout reset.
    always_comb begin
        id_busy = id_valid & stall_in;
        pc_hold = !rstd | !(accept | flush_in);
    end

    // Request is high exactly while a fetch is outstanding (WAIT or KILL).
    // The IF/ID update follows a strict priority: flush, stall-hold, skid
    // drain, fresh word, otherwise the register empties.
    always_ff @(posedge clk) begin
        if (!rstd) begin
            state      <= IDLE;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            req_pc     <= '0;
            id_valid   <= 1'b0;
            id_instr   <= NOP;
            id_pc      <= '0;
            skid_valid <= 1'b0;
            skid_instr <= NOP;
            skid_pc    <= '0;
        end else begin
            state    <= state_next;
            imem_req <= (state_next != IDLE);
            if (issue) begin
                imem_addr <= pc_in[ADDR_W-1:0];
                req_pc    <= pc_in;
            end

            if (flush_in) begin
                id_valid   <= 1'b0;
                id_instr   <= NOP;
                skid_valid <= 1'b0;
            end else if (id_busy) begin
                if (accept) begin
                    skid_valid <= 1'b1;
                    skid_instr <= imem_rdata;
                    skid_pc    <= req_pc;
                end
            end else if (skid_valid) begin
                id_valid   <= 1'b1;
                id_instr   <= skid_instr;
                id_pc      <= skid_pc;
                skid_valid <= 1'b0;
            end else if (accept) begin
                id_valid <= 1'b1;
                id_instr <= imem_rdata;
                id_pc    <= req_pc;
            end else begin
                id_valid <= 1'b0;
            end
        end
    end

    // Decoded fields are plain slices of the IF/ID word.
    always_comb begin
        id_op      = id_instr[31:26];
        id_rs      = id_instr[25:21];
        id_rt      = id_instr[20:16];
        id_imm_dpl = {{16{id_instr[15]}}, id_instr[15:0]};
        id_addr    = id_instr[25:0];
    end

endmodule

// File: tb/tb_if_id_stage.sv
// ---------------------------------------------------------------------------
// tb_if_id_stage
//
// Self-checking bench for if_id_stage. The bench plays the PC unit (advance
// on !pc_hold, load a target on flush) and instruction memory (either driven
// by hand or answering requests at random with a data word that is a fixed
// function of the address). Directed scenarios cover reset, streaming, field
// decode, stall/skid, flush/kill and reset during a fetch; a randomized run
// checks that decode sees every instruction exactly once, in PC order,
// restarting at the branch target after each flush.
// ---------------------------------------------------------------------------
module tb_if_id_stage;

    logic        clk;
    logic        rstd;
    logic [31:0] pc_in;
    logic        pc_hold;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall_in;
    logic        flush_in;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [5:0]  id_op;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [31:0] id_imm_dpl;
    logic [25:0] id_addr;

    int          checks;
    int          errors;
    bit          auto_mem;
    int          ack_pct;
    logic [31:0] target;

    if_id_stage #(.ADDR_W(32), .NOP(32'h00000000)) dut (
        .clk        (clk),
        .rstd       (rstd),
        .pc_in      (pc_in),
        .pc_hold    (pc_hold),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall_in   (stall_in),
        .flush_in   (flush_in),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_op      (id_op),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_imm_dpl (id_imm_dpl),
        .id_addr    (id_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of instruction memory: a scrambled but fixed word per address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    // One clock cycle: the PC unit reacts to pc_hold/flush at the edge, then at
    // the falling edge memory (in auto mode) answers a pending request.
    task automatic tick();
        logic hold_s;
        logic flush_s;
        logic rst_s;
        #1;
        hold_s  = pc_hold;
        flush_s = flush_in;
        rst_s   = rstd;
        @(posedge clk);
        #1;
        if (rst_s) begin
            if (flush_s) pc_in = target;
            else if (!hold_s) pc_in = pc_in + 32'd1;
        end
        @(negedge clk);
        if (auto_mem) begin
            imem_ack   = imem_req && ($urandom_range(0, 99) < ack_pct);
            imem_rdata = imem_ack ? word_of(imem_addr) : $urandom;
        end
    endtask

    task automatic do_reset(input logic [31:0] start);
        rstd       = 1'b0;
        stall_in   = 1'b0;
        flush_in   = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        pc_in      = start;
        tick();
        rstd = 1'b1;
    endtask

    task automatic wait_req(output bit ok);
        ok = imem_req;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            ok = imem_req;
        end
    endtask

    task automatic test_reset();
        auto_mem = 1'b0;
        rstd = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'hFFFFFFFF; pc_in = 32'h0; target = 32'h0;
        tick();
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req got %b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_addr got %h want 0", imem_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %b want 0", id_valid); end
        checks++; if (id_instr !== 32'h0) begin errors++; $display("[TB] FAIL rst_instr got %h want 0", id_instr); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc got %h want 0", id_pc); end
        #1;
        checks++; if (pc_hold !== 1'b1) begin errors++; $display("[TB] FAIL rst_hold got %b want 1", pc_hold); end
        flush_in = 1'b1;
        #1;
        checks++; if (pc_hold !== 1'b1) begin errors++; $display("[TB] FAIL rst_hold_flush got %b want 1", pc_hold); end
        flush_in = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        auto_mem = 1'b1;
        ack_pct  = 100;
        do_reset(32'h0);
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (id_valid !== ((k % 2) == 1)) begin
                errors++; $display("[TB] FAIL stream_valid[%0d] got %b want %b", k, id_valid, (k % 2) == 1);
            end
            if ((k % 2) == 1) begin
                exp_pc = (k - 1) / 2;
                checks++; if (id_pc !== exp_pc) begin errors++; $display("[TB] FAIL stream_pc[%0d] got %h want %h", k, id_pc, exp_pc); end
                checks++; if (id_instr !== word_of(exp_pc)) begin errors++; $display("[TB] FAIL stream_instr[%0d] got %h want %h", k, id_instr, word_of(exp_pc)); end
            end
        end
        auto_mem = 1'b0;
        imem_ack = 1'b0;
    endtask

    task automatic test_fields();
        bit          ok;
        logic [31:0] w;
        logic [31:0] imm16;
        logic [31:0] exp_imm;
        auto_mem = 1'b0;
        do_reset(32'h4);
        for (int n = 0; n < 2; n++) begin
            w = (n == 0) ? 32'h8C22FFFC : ($urandom & 32'hFFFF7FFF);
            wait_req(ok);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL fields_req[%0d] got 0 want 1", n); end
            imem_ack = 1'b1; imem_rdata = w;
            tick();
            imem_ack = 1'b0;
            imm16   = w & 32'h0000FFFF;
            exp_imm = (imm16 >= 32'd32768) ? imm16 - 32'd65536 : imm16;
            checks++; if (id_op !== 6'(w / 32'h04000000)) begin errors++; $display("[TB] FAIL fields_op[%0d] got %0d want %0d", n, id_op, w / 32'h04000000); end
            checks++; if (id_rs !== 5'((w / 32'h00200000) % 32)) begin errors++; $display("[TB] FAIL fields_rs[%0d] got %0d want %0d", n, id_rs, (w / 32'h00200000) % 32); end
            checks++; if (id_rt !== 5'((w / 32'h00010000) % 32)) begin errors++; $display("[TB] FAIL fields_rt[%0d] got %0d want %0d", n, id_rt, (w / 32'h00010000) % 32); end
            checks++; if (id_imm_dpl !== exp_imm) begin errors++; $display("[TB] FAIL fields_imm[%0d] got %h want %h", n, id_imm_dpl, exp_imm); end
            checks++; if (id_addr !== 26'(w % 32'h04000000)) begin errors++; $display("[TB] FAIL fields_addr[%0d] got %h want %h", n, id_addr, w % 32'h04000000); end
            if (n == 0) begin
                checks++; if (id_op !== 6'd35 || id_imm_dpl !== 32'hFFFFFFFC || id_addr !== 26'h022FFFC) begin
                    errors++; $display("[TB] FAIL fields_lw got op=%0d imm=%h addr=%h want 35 FFFFFFFC 022FFFC", id_op, id_imm_dpl, id_addr);
                end
            end
        end
    endtask

    task automatic test_stall_skid();
        bit ok;
        auto_mem = 1'b0;
        do_reset(32'h10);
        wait_req(ok);
        checks++; if (!ok || imem_addr !== 32'h10) begin errors++; $display("[TB] FAIL skid_req0 got req=%b addr=%h want 1 10", ok, imem_addr); end
        imem_ack = 1'b1; imem_rdata = word_of(32'h10);
        tick();
        imem_ack = 1'b0;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h10) begin errors++; $display("[TB] FAIL skid_first got v=%b pc=%h want 1 10", id_valid, id_pc); end
        stall_in = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h11) begin errors++; $display("[TB] FAIL skid_req1 got req=%b addr=%h want 1 11", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = word_of(32'h11);
        #1;
        checks++; if (pc_hold !== 1'b0) begin errors++; $display("[TB] FAIL skid_accept_hold got %b want 0", pc_hold); end
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'h10 || id_instr !== word_of(32'h10) || imem_req !== 1'b0) begin
                errors++; $display("[TB] FAIL skid_hold[%0d] got v=%b pc=%h instr=%h req=%b want 1 10 %h 0", i, id_valid, id_pc, id_instr, imem_req, word_of(32'h10));
            end
            if (i < 3) tick();
        end
        stall_in = 1'b0;
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h11 || id_instr !== word_of(32'h11)) begin
            errors++; $display("[TB] FAIL skid_drain got v=%b pc=%h instr=%h want 1 11 %h", id_valid, id_pc, id_instr, word_of(32'h11));
        end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL skid_drain_req got %b want 0", imem_req); end
        tick();
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h12) begin
            errors++; $display("[TB] FAIL skid_next got v=%b req=%b addr=%h want 0 1 12", id_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_flush_kill();
        bit ok;
        auto_mem = 1'b0;
        do_reset(32'h20);
        wait_req(ok);
        flush_in = 1'b1; target = 32'h40;
        #1;
        checks++; if (pc_hold !== 1'b0) begin errors++; $display("[TB] FAIL kill_flush_hold got %b want 0", pc_hold); end
        tick();
        flush_in = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin errors++; $display("[TB] FAIL kill_req got req=%b addr=%h want 1 20", imem_req, imem_addr); end
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL kill_req2 got %b want 1", imem_req); end
        imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
        #1;
        checks++; if (pc_hold !== 1'b1) begin errors++; $display("[TB] FAIL kill_ack_hold got %b want 1", pc_hold); end
        tick();
        imem_ack = 1'b0;
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL kill_drop got v=%b req=%b want 0 0", id_valid, imem_req); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("[TB] FAIL kill_refetch got req=%b addr=%h want 1 40", imem_req, imem_addr); end
    endtask

    task automatic test_flush_ack_stall();
        bit ok;
        auto_mem = 1'b0;
        do_reset(32'h30);
        wait_req(ok);
        imem_ack = 1'b1; imem_rdata = word_of(32'h30);
        tick();
        imem_ack = 1'b0;
        stall_in = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || id_valid !== 1'b1) begin errors++; $display("[TB] FAIL fas_setup got req=%b v=%b want 1 1", imem_req, id_valid); end
        imem_ack = 1'b1; imem_rdata = word_of(32'h31);
        flush_in = 1'b1; target = 32'h50;
        #1;
        checks++; if (pc_hold !== 1'b0) begin errors++; $display("[TB] FAIL fas_hold got %b want 0", pc_hold); end
        tick();
        imem_ack = 1'b0; flush_in = 1'b0;
        checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0 || imem_req !== 1'b0) begin
            errors++; $display("[TB] FAIL fas_flush got v=%b instr=%h req=%b want 0 0 0", id_valid, id_instr, imem_req);
        end
        tick();
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h50) begin
            errors++; $display("[TB] FAIL fas_skid_empty got v=%b req=%b addr=%h want 0 1 50", id_valid, imem_req, imem_addr);
        end
        stall_in = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        auto_mem = 1'b0;
        do_reset(32'h60);
        wait_req(ok);
        imem_ack = 1'b1; imem_rdata = word_of(32'h60);
        tick();
        imem_ack = 1'b0;
        stall_in = 1'b1;
        tick();
        rstd = 1'b0;
        #1;
        checks++; if (pc_hold !== 1'b1) begin errors++; $display("[TB] FAIL rmw_hold got %b want 1", pc_hold); end
        tick();
        rstd = 1'b1; stall_in = 1'b0;
        checks++; if (imem_req !== 1'b0 || id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 32'h0 || imem_addr !== 32'h0) begin
            errors++; $display("[TB] FAIL rmw_state got req=%b v=%b instr=%h pc=%h addr=%h want all 0", imem_req, id_valid, id_instr, id_pc, imem_addr);
        end
        imem_ack = 1'b1; imem_rdata = 32'hBADC0DE5;
        #1;
        checks++; if (pc_hold !== 1'b1) begin errors++; $display("[TB] FAIL rmw_late_hold got %b want 1", pc_hold); end
        tick();
        imem_ack = 1'b0;
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h61) begin
            errors++; $display("[TB] FAIL rmw_late_ack got v=%b req=%b addr=%h want 0 1 61", id_valid, imem_req, imem_addr);
        end
        imem_ack = 1'b1; imem_rdata = word_of(32'h61);
        tick();
        imem_ack = 1'b0;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h61 || id_instr !== word_of(32'h61)) begin
            errors++; $display("[TB] FAIL rmw_resume got v=%b pc=%h instr=%h want 1 61 %h", id_valid, id_pc, id_instr, word_of(32'h61));
        end
    endtask

    // Decode's view: every instruction it consumes must be the next PC in
    // program order with that address's memory word; a flush restarts the
    // expected sequence at the branch target.
    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        logic [31:0] start;
        int          delivered;
        auto_mem  = 1'b1;
        ack_pct   = 60;
        start     = $urandom;
        do_reset(start);
        exp_pc    = start;
        delivered = 0;
        for (int n = 0; n < 600; n++) begin
            stall_in = ($urandom_range(0, 99) < 30);
            flush_in = ($urandom_range(0, 99) < 4);
            if (flush_in) target = $urandom;
            if (id_valid && !stall_in) begin
                checks++;
                if (id_pc !== exp_pc || id_instr !== word_of(exp_pc)) begin
                    errors++; $display("[TB] FAIL b2b_word[%0d] got pc=%h instr=%h want %h %h", n, id_pc, id_instr, exp_pc, word_of(exp_pc));
                end
                exp_pc = exp_pc + 32'd1;
                delivered++;
            end
            if (flush_in) exp_pc = target;
            tick();
        end
        stall_in = 1'b0;
        flush_in = 1'b0;
        auto_mem = 1'b0;
        checks++; if (delivered < 40) begin errors++; $display("[TB] FAIL b2b_throughput got %0d want >= 40", delivered); end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        auto_mem = 1'b0;
        ack_pct  = 100;
        test_reset();
        test_stream();
        test_fields();
        test_stall_skid();
        test_flush_kill();
        test_flush_ack_stall();
        test_reset_mid_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
